// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 8:1 mux round-robin arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StOwn
  } arb_state_e;

  // Decode a select value into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping 7 -> 0.
// Purely combinational.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0] req_rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit 0 is the requester at ptr; index arithmetic wraps mod 8.
  always_comb begin
    req_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_rot[k] = req_i[ptr_i + SEL_W'(k)];
    end
  end

  // Lowest set bit of the rotated vector is the round-robin winner offset.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = SEL_W'(i);
    end
  end

  assign valid_o = |req_rot;
  assign idx_o   = ptr_i + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 single-bit mux. The select is driven
// first and held through a settle window before the one-hot grant is issued.
// Optional feature: define MUX_ARB_LOCK_EN to add a lock input that freezes the
// hold counter and suppresses the timeout while the owner keeps it high.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned HOLD_MAX   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       hold_q, hold_d;

  logic             lock_on;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_hit;
  logic             normal_rel;

`ifdef MUX_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  rr_pick u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state: pick in idle, count out the settle window, supervise the owner.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    settle_d   = settle_q;
    hold_d     = hold_q;
    hold_hit   = 1'b0;
    normal_rel = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d    = pick_idx;
          settle_d = '0;
          hold_d   = '0;
          if (SETTLE_CYC == 0) begin
            state_d = StOwn;
            grant_d = onehot(pick_idx);
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (32'(settle_q) == SETTLE_CYC - 32'd1) begin
          state_d  = StOwn;
          grant_d  = onehot(sel_q);
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StOwn: begin
        normal_rel = done || !req[sel_q];
        hold_hit   = (HOLD_MAX != 0) && (32'(hold_q) == HOLD_MAX - 32'd1) && !lock_on;
        if (normal_rel || hold_hit) begin
          state_d   = StIdle;
          grant_d   = '0;
          ptr_d     = sel_q + SEL_W'(1);
          hold_d    = '0;
          // A voluntary release in the same cycle wins over the forced one.
          timeout_d = !normal_rel;
        end else if (!lock_on) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset clears everything without a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      settle_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      settle_q  <= settle_d;
      hold_q    <= hold_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a behavioural model pushes the expected
// outputs after every clock edge and a monitor compares them on the falling edge.
module tb_mux8_rr_arbiter;

  localparam int unsigned SETTLE_CYC = 1;
  localparam int unsigned HOLD_MAX   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       done = 1'b0;
  logic       lock_v = 1'b0;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;

  mux8_rr_arbiter #(
    .SETTLE_CYC (SETTLE_CYC),
    .HOLD_MAX   (HOLD_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock_v),
`endif
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;
  } obs_t;

  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // First set request at or after p, searching upward and wrapping.
  function automatic int winner(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // Reference model: who owns the mux, how long, and who is next.
  int   m_owner  = -1;
  int   m_sel    = 0;
  int   m_ptr    = 0;
  int   m_settle = 0;
  int   m_age    = 0;
  bit   m_to;
  obs_t m_e;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_settle = 0; m_age = 0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (done || !req[m_owner]) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1;
        end else if (HOLD_MAX > 0 && m_age == int'(HOLD_MAX) - 1 && !lock_v) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
        end else if (!lock_v) begin
          m_age++;
        end
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin m_owner = m_sel; m_age = 0; end
      end else if (req != 8'h00) begin
        m_sel = winner(req, m_ptr);
        if (SETTLE_CYC == 0) begin m_owner = m_sel; m_age = 0; end
        else m_settle = int'(SETTLE_CYC);
      end
      m_e.sel     = 3'(m_sel);
      m_e.grant   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      m_e.busy    = (m_owner >= 0) || (m_settle > 0);
      m_e.timeout = m_to;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare every cycle away from the active edge.
  obs_t mon_e;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      check("reset_outputs", {19'd0, sel, grant, busy, timeout}, 32'd0);
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle_outputs", {19'd0, sel, grant, busy, timeout}, {19'd0, mon_e});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (grant != 8'h00) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("wait_grant", {31'd0, ok}, 32'd1);
  endtask

  task automatic go_idle();
    req  = 8'h00;
    done = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    int n;
    bit bad;
    #1 reset_n = 1'b0;
    #1 check("reset_state", {19'd0, sel, grant, busy, timeout}, 32'd0);
    repeat (3) step();

    // Release reset with all requests pending.
    reset_n = 1'b1;
    step();
    check("first_settle_busy", {31'd0, busy}, 32'd1);
    check("first_settle_grant", {24'd0, grant}, 32'd0);
    step();
    check("first_grant", {24'd0, grant}, 32'h01);

    // Rotation with done pulsed in each ownership.
    for (int r = 0; r < 9; r++) begin
      wait_grant(20);
      check("rotate", {24'd0, grant}, 32'(1 << (r % 8)));
      done = 1'b1;
      step();
      done = 1'b0;
    end
    go_idle();

    // Single requester never done: forced release after HOLD_MAX cycles.
    req = 8'h20;
    wait_grant(20);
    n = 0;
    while (grant != 8'h00 && n < 64) begin
      n++;
      step();
    end
    check("hold_len", n, HOLD_MAX);
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    step();
    check("timeout_one_cycle", {31'd0, timeout}, 32'd0);
    go_idle();

    // done coincides with the timeout cycle: normal release.
    req = 8'h04;
    wait_grant(20);
    repeat (HOLD_MAX - 1) step();
    check("last_hold_cycle", {24'd0, grant}, 32'h04);
    done = 1'b1;
    step();
    done = 1'b0;
    check("coincide_grant", {24'd0, grant}, 32'd0);
    check("coincide_timeout", {31'd0, timeout}, 32'd0);
    go_idle();

    // Requester withdraws mid-ownership.
    req = 8'h08;
    wait_grant(20);
    repeat (5) step();
    req = 8'h00;
    step();
    check("withdraw_grant", {24'd0, grant}, 32'd0);
    check("withdraw_timeout", {31'd0, timeout}, 32'd0);
    go_idle();

    // Randomized traffic with slowly changing requests.
    req = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(15) == 0) req = 8'h00;
      done = ($urandom_range(9) == 0);
      step();
    end
    go_idle();

    // Asynchronous reset while an owner holds the grant.
    req = 8'hFF;
    wait_grant(20);
    step();
    #1 reset_n = 1'b0;
    #1 check("async_reset", {19'd0, sel, grant, busy, timeout}, 32'd0);
    step();
    reset_n = 1'b1;
    go_idle();

`ifdef MUX_ARB_LOCK_EN
    // Locked owner keeps the grant well past HOLD_MAX with no timeout.
    lock_v = 1'b1;
    req    = 8'h40;
    wait_grant(20);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (grant != 8'h40 || timeout) bad = 1'b1;
      step();
    end
    check("lock_hold", {31'd0, bad}, 32'd0);
    lock_v = 1'b0;
    repeat (30) step();
    go_idle();
`else
    bad = 1'b0;
`endif

    check("check_volume", {31'd0, (n_chk > 500)}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
